// File: rtl/conv_stream_feeder.sv
// Streams one feature map into a 3x3 convolutor in raster order with column-edge
// flags and flush zeros, captures the aligned results, then clears the convolutor.
module conv_stream_feeder #(
  parameter int MAX_WIDTH = 128,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        width,
  input  logic [7:0]        height,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        pixel_out,
  output logic              paddingl,
  output logic              paddingr,
  output logic              conv_rst_n,
  input  logic [31:0]       conv_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  // Stream index must hold N+W for the largest map without wrapping.
  localparam int SPAN    = MAX_WIDTH * MAX_WIDTH + MAX_WIDTH;
  localparam int CNT_MIN = $clog2(SPAN + 1);
  localparam int SW      = (ADDR_W + 1 > CNT_MIN) ? ADDR_W + 1 : CNT_MIN;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    STREAM = 3'd2,
    CLEAR  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        w_q;
  logic [7:0]        col_q;
  logic [SW-1:0]     n_q;
  logic [SW-1:0]     last_q;
  logic [SW-1:0]     s_q;
  logic [SW-1:0]     s_inc;
  logic [SW-1:0]     w_ext;
  logic [ADDR_W-1:0] wa_q;
  logic              s_lt_n;
  logic              rd_more;
  logic              wr_act;

  assign w_ext   = SW'(w_q);
  assign s_inc   = s_q + SW'(1);
  assign s_lt_n  = s_q < n_q;
  assign rd_more = s_inc < n_q;
  // Result for pixel s-W-1 is valid once its bottom-right neighbour is on pixel_in.
  assign wr_act  = s_q > w_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   state_nxt = STREAM;
      STREAM:  if (s_q == last_q) state_nxt = CLEAR;
      CLEAR:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      n_q    <= '0;
      last_q <= '0;
      s_q    <= '0;
      col_q  <= '0;
      wa_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w_q <= width;
          n_q <= SW'(width) * SW'(height);
        end
        PRIME: begin
          last_q <= n_q + w_ext;
          s_q    <= '0;
          col_q  <= '0;
          wa_q   <= '0;
        end
        STREAM: begin
          s_q   <= s_inc;
          col_q <= (col_q == w_q - 8'd1) ? 8'd0 : col_q + 8'd1;
          if (wr_act) wa_q <= wa_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered so the convolutor's clear input never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conv_rst_n <= 1'b1;
    else        conv_rst_n <= (state_nxt != CLEAR);
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    pixel_out = '0;
    paddingl  = 1'b0;
    paddingr  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      PRIME: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      STREAM: begin
        busy      = 1'b1;
        pixel_out = s_lt_n ? rd_data : 8'd0;
        paddingl  = (col_q == 8'd0);
        paddingr  = (col_q == 8'd1);
        rd_en     = rd_more;
        rd_addr   = rd_more ? s_inc[ADDR_W-1:0] : '0;
        wr_en     = wr_act;
        if (wr_act) begin
          wr_addr = wa_q;
          wr_data = conv_result;
        end
      end
      CLEAR:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: buffer + convolutor models around the DUT, per-cycle
// expectations from the streaming rules, results against a direct 2-D convolution.
module tb_conv_stream_feeder;
  localparam int ADDR_W = 14;
  localparam int HMAX   = 258;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        width = '0;
  logic [7:0]        height = '0;
  logic              busy, done, rd_en, paddingl, paddingr, conv_rst_n, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]        rd_data = '0;
  logic [7:0]        pixel_out;
  logic [31:0]       conv_result;
  logic [31:0]       wr_data;

  conv_stream_feeder #(.MAX_WIDTH(128), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_out(pixel_out), .paddingl(paddingl), .paddingr(paddingr),
    .conv_rst_n(conv_rst_n), .conv_result(conv_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  int cur_k = 0;
  int cur_w = 4;
  logic signed [7:0] img [0:16383];
  logic signed [7:0] hist [1:HMAX];
  int s1_img [16];
  int s1_exp [16];

  typedef struct {
    int w; int h; int mode; int extra;
    int exp_n; int exp_first; int exp_done;
  } vec_t;
  vec_t vt [0:11];

  function automatic int wt(int dr, int dc);
    case ((dr + 1) * 3 + dc + 1)
      1:       return 1;
      3, 5:    return -1;
      4:       return 39;
      7:       return 2;
      default: return 0;
    endcase
  endfunction

  // Input buffer: synchronous read.
  always @(posedge clk) if (rd_en) rd_data <= img[rd_addr];

  // Convolutor: window spans the last 2W+2 pixels plus the one on pixel_in.
  wire crst = rst_n & conv_rst_n;
  always @(posedge clk or negedge crst) begin
    if (!crst) begin
      for (int i = 1; i <= HMAX; i++) hist[i] <= '0;
    end else begin
      for (int i = HMAX; i >= 2; i--) hist[i] <= hist[i-1];
      hist[1] <= $signed(pixel_out);
    end
  end

  always_comb begin
    int acc;
    int off;
    int px;
    acc = -1;
    off = 0;
    px  = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        off = (1 - dr) * cur_w + (1 - dc);
        if (off == 0) px = int'($signed(pixel_out));
        else          px = int'(hist[off]);
        if ((dc == -1 && paddingr) || (dc == 1 && paddingl)) px = 0;
        acc = acc + wt(dr, dc) * px;
      end
    conv_result = (acc < 0) ? 32'd0 : 32'(acc);
  end

  function automatic int golden(int w, int h, int idx);
    int r, c, rr, cc, acc;
    r = idx / w;
    c = idx % w;
    acc = -1;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          acc = acc + wt(dr, dc) * int'(img[rr * w + cc]);
      end
    return (acc < 0) ? 0 : acc;
  endfunction

  function automatic void check(string nm, int got, int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      if (nbad <= 40) $display("FAIL %s k=%0d got %0d want %0d", nm, cur_k, got, exp);
    end
  endfunction

  task automatic check_reset_vals();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_padl", int'(paddingl), 0);
    check("rst_padr", int'(paddingr), 0);
    check("rst_conv_rst_n", int'(conv_rst_n), 1);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
  endtask

  task automatic load_img(int w, int h, int mode);
    cur_w = w;
    if (mode == 0) for (int i = 0; i < 16; i++) img[i] = 8'(s1_img[i]);
    else           for (int i = 0; i < w * h; i++) img[i] = 8'($urandom);
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic run_map(input vec_t v);
    int n, s, fw, dn, nw;
    bit strm, erd, ewr;
    n = v.w * v.h;
    fw = -1; dn = -1; nw = 0;
    load_img(v.w, v.h, v.mode);
    width  = 8'(v.w);
    height = 8'(v.h);
    start  = 1'b1;
    for (int k = 1; k <= v.exp_done; k++) begin
      @(negedge clk);
      cur_k = k;
      start = (k == v.extra);
      s    = k - 2;
      strm = (s >= 0 && s <= n + v.w);
      erd  = (k == 1) || (strm && s + 1 < n);
      ewr  = strm && s >= v.w + 1;
      check("busy", int'(busy), int'(k <= n + v.w + 3));
      check("done", int'(done), int'(k == n + v.w + 4));
      check("conv_rst_n", int'(conv_rst_n), int'(k != n + v.w + 3));
      check("pixel_out", int'($signed(pixel_out)), (strm && s < n) ? int'(img[s]) : 0);
      check("paddingl", int'(paddingl), int'(strm && (s % v.w == 0)));
      check("paddingr", int'(paddingr), int'(strm && (s % v.w == 1)));
      check("rd_en", int'(rd_en), int'(erd));
      if (erd) check("rd_addr", int'(rd_addr), (k == 1) ? 0 : s + 1);
      check("wr_en", int'(wr_en), int'(ewr));
      if (ewr) begin
        check("wr_addr", int'(wr_addr), s - v.w - 1);
        check("wr_data", int'(wr_data), golden(v.w, v.h, s - v.w - 1));
        if (v.mode == 0) check("s1_data", int'(wr_data), s1_exp[s - v.w - 1]);
      end
      if (wr_en) begin
        nw++;
        if (fw < 0) fw = k;
      end
      if (done && dn < 0) dn = k;
    end
    check("first_wr_cycle", fw, v.exp_first);
    check("done_cycle", dn, v.exp_done);
    check("write_count", nw, v.exp_n);
    @(negedge clk);
    cur_k++;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
  endtask

  function automatic vec_t mk(int w, int h, int mode, int extra);
    vec_t v;
    v.w = w; v.h = h; v.mode = mode; v.extra = extra;
    v.exp_n = w * h;
    v.exp_first = w + 3;
    v.exp_done = w * h + w + 4;
    return v;
  endfunction

  initial begin
    s1_img = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
    s1_exp = '{544, 22, 0, 3699, 14, 0, 100, 0, 1, 2, 0, 0, 36, 76, 0, 38};
    vt[0]  = mk(4, 4, 0, 0);
    vt[1]  = mk(4, 4, 1, 0);
    vt[2]  = mk(2, 3, 1, 0);
    vt[3]  = mk(4, 4, 0, 5);
    vt[4]  = mk(5, 1, 1, 0);
    vt[5]  = mk(2, 1, 1, 0);
    vt[6]  = mk(128, 2, 1, 0);
    for (int i = 7; i <= 10; i++)
      vt[i] = mk($urandom_range(2, 16), $urandom_range(1, 10), 1, $urandom_range(2, 8));
    vt[11] = mk(128, 128, 1, 0);

    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_map(vt[i]);

    // Reset at s=7 of a 4x4 map, then a clean rerun.
    load_img(4, 4, 0);
    width = 8'd4; height = 8'd4; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      cur_k = k;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    run_map(vt[0]);

    // Back-to-back maps, second start in the cycle after done.
    run_map(vt[0]);
    run_map(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Drives one 3x3 convolutor (pixel_in/paddingl/paddingr/reset side) from an 8-bit feature-map buffer and writes the convolutor's 32-bit results to an output buffer.
- It is the producer/consumer end of the convolutor stream protocol: raster-order pixels, column padding flags, flush zeros, aligned result capture, and a post-map convolutor clear.
- Sits between the layer buffers and each convolutor instance in the U-Net layer controller.

Parameters:
- MAX_WIDTH, 128, largest supported map width/height.
- ADDR_W, 14, address width of both buffers; must satisfy 2^ADDR_W >= MAX_WIDTH*MAX_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- width  in  8  map width W, 2..MAX_WIDTH; latched on start.
- height  in  8  map height H, 1..MAX_WIDTH; latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the map is complete.
- rd_en  out  1  input-buffer read enable.
- rd_addr  out  ADDR_W  input-buffer address; synchronous read, data valid the next cycle.
- rd_data  in  8  signed pixel from the input buffer.
- pixel_out  out  8  signed pixel to the convolutor pixel_in.
- paddingl  out  1  left-edge flag to the convolutor.
- paddingr  out  1  right-edge flag to the convolutor.
- conv_rst_n  out  1  active-low clear to the convolutor; ANDed with rst_n at instantiation.
- conv_result  in  32  signed convolutor pixel_out (bias and relu applied inside the convolutor).
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  ADDR_W  output-buffer address.
- wr_data  out  32  result written to the output buffer.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, pixel_out=0, paddingl=0, paddingr=0, conv_rst_n=1, wr_en=0, wr_addr=0, wr_data=0; FSM=IDLE.
- FSM states: IDLE -> PRIME -> STREAM -> CLEAR -> DONE -> IDLE.
- IDLE: on start, latch W and H, compute N=H*W, go to PRIME. A start outside IDLE is ignored.
- PRIME (1 cycle): rd_en=1, rd_addr=0. Stream index s=0.
- STREAM, for s = 0 .. N+W (N+W+1 cycles):
  - pixel_out = rd_data when s<N, else 0.
  - paddingl = (s mod W == 0); paddingr = (s mod W == 1). These come from a column counter that wraps at W-1; no divider is used.
  - rd_en=1 and rd_addr=s+1 while s+1<N; otherwise rd_en=0.
  - When s>=W+1: wr_en=1, wr_addr=s-W-1, wr_data=conv_result (the combinational convolutor output in that cycle).
- Latency: start is sampled at cycle 0; pixel_out=img[0] appears at cycle 2; first write at cycle W+3; last write at cycle N+W+2.
- Exactly N writes per map, addresses 0..N-1, ascending, no gaps.
- CLEAR (1 cycle): conv_rst_n=0; all write and read strobes low.
- DONE (1 cycle): done=1, busy=0 in the same cycle; next state IDLE.
- H=1: the stream is W+1+W cycles and all flush pixels are 0.
- rst_n low mid-map: immediate return to reset values; no partial done pulse. The convolutor is cleared through the ANDed reset.
- Products/widths: s counter is ADDR_W+1 bits wide to hold N+W without wrap at MAX_WIDTH*MAX_WIDTH+MAX_WIDTH.

Test Plan:
1. Behavioural convolutor model; W=H=4; weights 0,1,0 / -1,39,-1 / 0,2,0; bias -1; relu on; image 14,1,0,100, 0,-1,0,-100, 0,0,0,0, 1,2,0,1 -> writes to addrs 0..15 = 544,22,0,3699, 14,0,100,0, 1,2,0,0, 36,76,0,38; then done one cycle after the conv_rst_n low cycle.
2. W=4, H=4 -> paddingl high at s=0,4,8,12,16,20; paddingr high at s=1,5,9,13,17; pixel_out=0 for s=16..20; exactly 16 wr_en pulses.
3. W=2, H=3 -> N=6; STREAM lasts 9 cycles; first write at cycle 5; wr_addr sequence 0..5; rd_addr never exceeds 5.
4. Second start pulse at cycle 5 of a running map -> ignored; write count and done timing identical to a single-start run.
5. rst_n low at s=7 of a 4x4 map -> all outputs go to reset values asynchronously; no done pulse; a fresh start then gives the full scenario-1 result.
6. Back-to-back maps, with start issued in the cycle after done -> the second map's first pixel at start+2; conv_rst_n was pulsed low between the maps; results are identical to the first map.
